// File: rtl/demux_stream_1xn_pkg.sv
// demux_stream_pkg: FSM states and drop-counter constants for the stream demux
package demux_stream_pkg;
  typedef enum logic {IDLE, PKT} state_t;
  localparam int DROP_CNT_W = 8;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] c);
    return (c == DROP_CNT_MAX) ? c : c + 1'b1;
  endfunction
endpackage

// File: rtl/demux_stream_1xn_if.sv
// demux_stream_1xn_if: upstream beat, per-output streams and drop status
interface demux_stream_1xn_if
  import demux_stream_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 4,
  parameter int SEL_W  = $clog2(N_OUT)
) ();
  logic [DATA_W-1:0]       in_data;
  logic                    in_valid;
  logic                    in_last;
  logic [SEL_W-1:0]        s;
  logic                    in_ready;
  logic [N_OUT*DATA_W-1:0] y_data;
  logic [N_OUT-1:0]        y_last;
  logic [N_OUT-1:0]        y_valid;
  logic [N_OUT-1:0]        y_ready;
  logic                    err_sel;
  logic [DROP_CNT_W-1:0]   drop_cnt;
  modport master (
    output in_data, in_valid, in_last, s, y_ready,
    input  in_ready, y_data, y_last, y_valid, err_sel, drop_cnt
  );
  modport slave (
    input  in_data, in_valid, in_last, s, y_ready,
    output in_ready, y_data, y_last, y_valid, err_sel, drop_cnt
  );
endinterface

// File: rtl/demux_stream_1xn_slice.sv
// demux_out_slice: one-entry output register; a load wins over a same-cycle drain
module demux_out_slice #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              ready,
  output logic [DATA_W-1:0] data,
  output logic              last,
  output logic              valid
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      last  <= 1'b0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= in_data;
      last  <= in_last;
      valid <= 1'b1;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/demux_stream_1xn.sv
// demux_stream_1xn: registered 1-to-N packet demux; out-of-range packets are dropped and counted
module demux_stream_1xn
  import demux_stream_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 4,
  parameter int SEL_W  = $clog2(N_OUT)
) (
  input logic              clk,
  input logic              rst_n,
  demux_stream_1xn_if.slave bus
);
  localparam int N_SEL = 2 ** SEL_W;
  state_t                state_q, state_d;
  logic [SEL_W-1:0]      sel_q, tgt;
  logic [N_SEL-1:0]      free, in_range;
  logic                  acc, drop, err_q;
  logic [DROP_CNT_W-1:0] cnt_q;
  assign tgt          = (state_q == PKT) ? sel_q : bus.s;
  assign bus.in_ready = free[tgt];
  assign acc          = bus.in_valid && bus.in_ready;
  assign drop         = acc && !in_range[tgt];
  assign bus.err_sel  = err_q;
  assign bus.drop_cnt = cnt_q;
  // Select codes past N_OUT map to an always-free sink so dropped packets never stall
  for (genvar i = 0; i < N_SEL; i++) begin : g_sel
    if (i < N_OUT) begin : g_out
      assign in_range[i] = 1'b1;
      assign free[i]     = !bus.y_valid[i] || bus.y_ready[i];
      demux_out_slice #(.DATA_W(DATA_W)) u_slice (
        .clk,
        .rst_n,
        .load   (acc && tgt == SEL_W'(i)),
        .in_data(bus.in_data),
        .in_last(bus.in_last),
        .ready  (bus.y_ready[i]),
        .data   (bus.y_data[i*DATA_W +: DATA_W]),
        .last   (bus.y_last[i]),
        .valid  (bus.y_valid[i])
      );
    end else begin : g_void
      assign in_range[i] = 1'b0;
      assign free[i]     = 1'b1;
    end
  end
  always_comb begin
    state_d = state_q;
    if (acc) state_d = bus.in_last ? IDLE : PKT;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      if (acc && state_q == IDLE) sel_q <= bus.s;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      err_q <= drop && state_q == IDLE;
      if (drop) cnt_q <= sat_inc(cnt_q);
    end
  end
endmodule

// File: tb/tb_demux_stream_1xn.sv
// tb_demux_stream_1xn: directed and random traffic on a 4-output and a 3-output demux against a beat-level model
module tb_demux_stream_1xn;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  demux_stream_1xn_if #(.DATA_W(8), .N_OUT(4)) b4 ();
  demux_stream_1xn_if #(.DATA_W(8), .N_OUT(3)) b3 ();
  demux_stream_1xn #(.DATA_W(8), .N_OUT(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  demux_stream_1xn #(.DATA_W(8), .N_OUT(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));
  logic [7:0] i_dat [2];
  logic       i_val [2];
  logic       i_lst [2];
  logic [1:0] i_s   [2];
  logic [3:0] i_yr  [2];
  assign b4.in_data  = i_dat[0];
  assign b4.in_valid = i_val[0];
  assign b4.in_last  = i_lst[0];
  assign b4.s        = i_s[0];
  assign b4.y_ready  = i_yr[0];
  assign b3.in_data  = i_dat[1];
  assign b3.in_valid = i_val[1];
  assign b3.in_last  = i_lst[1];
  assign b3.s        = i_s[1];
  assign b3.y_ready  = i_yr[1][2:0];
  logic       o_rdy [2];
  logic       o_err [2];
  logic [7:0] o_cnt [2];
  logic [3:0] o_yv  [2];
  logic [3:0] o_yl  [2];
  logic [7:0] o_yd  [2][4];
  assign o_rdy[0] = b4.in_ready;
  assign o_rdy[1] = b3.in_ready;
  assign o_err[0] = b4.err_sel;
  assign o_err[1] = b3.err_sel;
  assign o_cnt[0] = b4.drop_cnt;
  assign o_cnt[1] = b3.drop_cnt;
  assign o_yv[0]  = b4.y_valid;
  assign o_yv[1]  = {1'b0, b3.y_valid};
  assign o_yl[0]  = b4.y_last;
  assign o_yl[1]  = {1'b0, b3.y_last};
  assign o_yd[1][3] = 8'h00;
  for (genvar k = 0; k < 4; k++) begin : g_o4
    assign o_yd[0][k] = b4.y_data[k*8 +: 8];
  end
  for (genvar k = 0; k < 3; k++) begin : g_o3
    assign o_yd[1][k] = b3.y_data[k*8 +: 8];
  end
  // Model: each output is a one-deep buffer; a packet's destination is the select of its first beat
  int         n_out [2] = '{4, 3};
  bit         m_v   [2][4];
  logic [7:0] m_d   [2][4];
  bit         m_l   [2][4];
  bit         m_pkt [2];
  int         m_tgt [2];
  int         m_cnt [2];
  bit         m_err [2];
  bit         acc_q [2];
  int n_assert = 0;
  int n_fail = 0;
  task automatic chk(string tag, int d, logic [31:0] o, logic [31:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, o, e);
    end
  endtask
  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_pkt[d] = 0;
      m_tgt[d] = 0;
      m_cnt[d] = 0;
      m_err[d] = 0;
      acc_q[d] = 0;
      for (int k = 0; k < 4; k++) m_v[d][k] = 0;
    end
  endtask
  function automatic int dest(int d);
    return m_pkt[d] ? m_tgt[d] : int'(i_s[d]);
  endfunction
  function automatic bit exp_rdy(int d);
    int t;
    t = dest(d);
    if (t >= n_out[d]) return 1'b1;
    return !m_v[d][t] || i_yr[d][t];
  endfunction
  task automatic check_all();
    logic [3:0] ev;
    for (int d = 0; d < 2; d++) begin
      ev = '0;
      for (int k = 0; k < n_out[d]; k++) begin
        ev[k] = m_v[d][k];
        if (m_v[d][k]) begin
          chk("y_data", d, 32'(o_yd[d][k]), 32'(m_d[d][k]));
          chk("y_last", d, 32'(o_yl[d][k]), 32'(m_l[d][k]));
        end
      end
      chk("in_ready", d, 32'(o_rdy[d]), 32'(exp_rdy(d)));
      chk("y_valid", d, 32'(o_yv[d]), 32'(ev));
      chk("err_sel", d, 32'(o_err[d]), 32'(m_err[d]));
      chk("drop_cnt", d, 32'(o_cnt[d]), 32'(m_cnt[d]));
    end
  endtask
  task automatic update();
    bit a;
    int t;
    for (int d = 0; d < 2; d++) begin
      a = i_val[d] && exp_rdy(d);
      t = dest(d);
      for (int k = 0; k < n_out[d]; k++) if (m_v[d][k] && i_yr[d][k]) m_v[d][k] = 0;
      m_err[d] = 0;
      if (a) begin
        if (t >= n_out[d]) begin
          if (m_cnt[d] < 255) m_cnt[d]++;
          m_err[d] = !m_pkt[d];
        end else begin
          m_v[d][t] = 1;
          m_d[d][t] = i_dat[d];
          m_l[d][t] = i_lst[d];
        end
        m_tgt[d] = t;
        m_pkt[d] = !i_lst[d];
      end
      acc_q[d] = a;
    end
  endtask
  task automatic step();
    #1;
    check_all();
    @(posedge clk);
    update();
    @(negedge clk);
  endtask
  task automatic send(int d, logic [7:0] dat, bit last, logic [1:0] s);
    i_dat[d] = dat;
    i_lst[d] = last;
    i_s[d]   = s;
    i_val[d] = 1'b1;
    for (int n = 0; n < 50; n++) begin
      step();
      if (acc_q[d]) break;
    end
    if (!acc_q[d]) begin
      n_fail++;
      $error("FAIL accept_timeout dut%0d observed=stalled expected=accepted", d);
    end
    i_val[d] = 1'b0;
  endtask
  initial begin
    for (int d = 0; d < 2; d++) begin
      i_dat[d] = '0;
      i_val[d] = 1'b0;
      i_lst[d] = 1'b0;
      i_s[d]   = '0;
      i_yr[d]  = '0;
    end
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", 0, 32'(o_rdy[0]), 1);
    chk("rst_y_valid", 0, 32'(o_yv[0]), 0);
    chk("rst_err_sel", 1, 32'(o_err[1]), 0);
    chk("rst_drop_cnt", 1, 32'(o_cnt[1]), 0);
    rst_n = 1'b1;
    @(negedge clk);
    step();
    // single-beat routing to every output
    i_yr[0] = 4'hF;
    for (int s = 0; s < 4; s++) begin
      send(0, 8'hA0 + 8'(s), 1'b1, 2'(s));
      chk("route_valid", 0, 32'(o_yv[0]), 32'(1 << s));
      chk("route_data", 0, 32'(o_yd[0][s]), 32'(8'hA0 + 8'(s)));
      step();
      chk("route_drained", 0, 32'(o_yv[0]), 0);
    end
    // select is latched on the first beat only
    send(0, 8'h11, 1'b0, 2'd2);
    send(0, 8'h12, 1'b0, 2'd1);
    chk("latch_beat2", 0, 32'(o_yv[0]), 32'h4);
    send(0, 8'h13, 1'b1, 2'd3);
    chk("latch_beat3", 0, 32'(o_yv[0]), 32'h4);
    chk("latch_last", 0, 32'(o_yl[0][2]), 1);
    send(0, 8'h14, 1'b1, 2'd0);
    chk("latch_idle", 0, 32'(o_yv[0]), 32'h1);
    step();
    // backpressure on output 1, then drain and load in one cycle
    i_yr[0] = 4'b1101;
    send(0, 8'h31, 1'b1, 2'd1);
    i_dat[0] = 8'h32;
    i_lst[0] = 1'b1;
    i_s[0]   = 2'd1;
    i_val[0] = 1'b1;
    step();
    chk("bp_stall", 0, 32'(o_rdy[0]), 0);
    chk("bp_hold", 0, 32'(o_yd[0][1]), 32'h31);
    i_yr[0] = 4'hF;
    #1;
    chk("bp_ready", 0, 32'(o_rdy[0]), 1);
    step();
    chk("bp_valid", 0, 32'(o_yv[0][1]), 1);
    chk("bp_data", 0, 32'(o_yd[0][1]), 32'h32);
    i_val[0] = 1'b0;
    step();
    // out-of-range select on the 3-output instance
    i_yr[1] = 4'hF;
    send(1, 8'h01, 1'b0, 2'd3);
    chk("err_pulse", 1, 32'(o_err[1]), 1);
    send(1, 8'h02, 1'b0, 2'd0);
    chk("err_once", 1, 32'(o_err[1]), 0);
    send(1, 8'h03, 1'b0, 2'd1);
    send(1, 8'h04, 1'b1, 2'd2);
    chk("drop_4", 1, 32'(o_cnt[1]), 4);
    chk("drop_no_valid", 1, 32'(o_yv[1]), 0);
    for (int i = 0; i < 300; i++) send(1, 8'(i), i == 299, 2'd3);
    chk("drop_sat", 1, 32'(o_cnt[1]), 255);
    step();
    // reset in the middle of a packet
    send(0, 8'h41, 1'b0, 2'd0);
    send(0, 8'h42, 1'b0, 2'd0);
    chk("pre_rst_valid", 0, 32'(o_yv[0][0]), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 0, 32'(o_yv[0]), 0);
    chk("rst_mid_cnt", 1, 32'(o_cnt[1]), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    send(0, 8'h55, 1'b1, 2'd3);
    chk("post_rst_route", 0, 32'(o_yv[0]), 32'h8);
    chk("post_rst_data", 0, 32'(o_yd[0][3]), 32'h55);
    // random traffic on both instances
    for (int c = 0; c < 1500; c++) begin
      for (int d = 0; d < 2; d++) begin
        i_val[d] = $urandom_range(0, 3) != 0;
        i_dat[d] = 8'($urandom);
        i_lst[d] = $urandom_range(0, 2) == 0;
        i_s[d]   = 2'($urandom);
        i_yr[d]  = 4'($urandom);
      end
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/demux_stream_1xn.md
# demux_stream_1xn

Parametrised, registered 1-to-N stream demultiplexer with valid/ready handshaking and packet-level routing. It generalises the fixed 1x4 combinational demux: configurable data width and output count, a per-output register slot, and select latching for a whole packet. It sits between a single upstream source and N independent downstream consumers in the datapath. Out-of-range selects are dropped and counted.

## Interface

Parameters:
- DATA_W, 8, width of each data beat
- N_OUT, 4, number of output channels (≥2)
- SEL_W, $clog2(N_OUT), select width (derived; do not override)

Ports:
- clk  in  1  single clock; all logic is on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_data  in  DATA_W  input beat
- in_valid  in  1  input beat valid
- in_last  in  1  final beat of packet
- s  in  SEL_W  destination select; sampled on a packet's first beat only
- in_ready  out  1  input accepted when in_valid && in_ready
- y_data  out  N_OUT*DATA_W  output k occupies bits [k*DATA_W +: DATA_W]
- y_last  out  N_OUT  per-output last flag
- y_valid  out  N_OUT  per-output valid
- y_ready  in  N_OUT  per-output ready
- err_sel  out  1  one-cycle pulse on acceptance of a first beat with s ≥ N_OUT
- drop_cnt  out  8  saturating count of dropped beats

## Operation

- FSM states: IDLE (awaiting first beat) and PKT (mid-packet).
- IDLE: on accept, sel_q <= s. If in_last is set, stay in IDLE; otherwise go to PKT.
- PKT: s is ignored and beats route to sel_q. Accepting a beat with in_last returns the FSM to IDLE.
- The routing target is s in IDLE and sel_q in PKT.
- Each output has a one-entry slot holding {data, last, valid}.
  - Slot k loads when a beat is accepted with target k.
  - Slot k clears when y_valid[k] && y_ready[k] and no new load occurs.
  - Simultaneous drain and load: the slot takes the new beat and y_valid stays 1.
- in_ready:
  - Valid target: in_ready = !y_valid[t] || y_ready[t].
  - Invalid target (t ≥ N_OUT): in_ready = 1.
  - in_ready depends on y_ready combinationally; no input-to-output combinational path exists on data.
- Invalid select (t ≥ N_OUT):
  - The entire packet is accepted and discarded.
  - err_sel pulses once, on the first beat only.
  - drop_cnt increments per dropped beat and saturates at 255.
- Other outputs are unaffected by traffic to one output. Blocking is head-of-line only: the input stalls while its target is full.
- Reset values: y_valid=0, y_data=0, y_last=0, err_sel=0, drop_cnt=0, state=IDLE, sel_q=0. in_ready follows combinationally (1 after reset, since all slots are empty).
- Reset mid-packet: all slots are emptied immediately and the partial packet is lost. The next accepted beat is treated as a first beat.

## Timing

- Latency: a beat accepted at edge n is visible on y_*[t] after edge n, i.e. in cycle n+1.
- Throughput: 1 beat/cycle per stream when the target's y_ready is held at 1.
- y_valid[k], once asserted, holds with stable y_data[k] and y_last[k] until it is drained.
- err_sel is registered and asserts in the cycle after the offending accept.
- drop_cnt updates in the cycle after each dropped accept.

## Structure

- Package demux_stream_pkg holds:
  - the state enum {IDLE, PKT}
  - DROP_CNT_W = 8 and the saturation constant
- Sub-module demux_out_slice (parameter DATA_W): one-entry slot with load/drain logic, instantiated N_OUT times in a generate loop.
- The top level contains the FSM, sel_q, the target mux, the in_ready mux and the drop counter.

## Test plan

- **Reset/idle:** drive rst_n=0, then release → all y_valid=0, in_ready=1, drop_cnt=0, err_sel=0.
- **Single-beat routing:** N_OUT=4, for each s=0..3 send data=8'hA0+s with last=1 and y_ready=all 1 → only y_valid[s] is high, for exactly one cycle after accept, with the matching data.
- **Packet latch:** send a 3-beat packet with s=2, changing s to 1 and then 3 on beats 2 and 3 → all three beats appear on output 2, y_last is high on beat 3 only, and the FSM returns to IDLE.
- **Backpressure:** hold y_ready[1]=0 and send 2 beats to output 1 → the first beat is held on y_data[1] and in_ready=0 on the second beat. Then raise y_ready[1] → the second beat is accepted in the same cycle as the drain, and y_valid[1] stays high.
- **Invalid select:** N_OUT=3, send a 4-beat packet with s=3 → in_ready=1 throughout, no y_valid asserts, err_sel pulses once, drop_cnt=4. Then send 300 more dropped beats → drop_cnt=255.
- **Reset mid-packet:** assert rst_n=0 after 2 beats of a 5-beat packet to output 0 → y_valid[0]=0 immediately. After release, a new beat with s=3 is routed to output 3.
